// File: rtl/alu_control_pkg.sv
// alu_control_pkg: funct codes, result-mux selects, FSM states and the funct decoder
package alu_control_pkg;
  localparam logic [5:0] ADD   = 6'b100000;
  localparam logic [5:0] SUB   = 6'b100010;
  localparam logic [5:0] AND   = 6'b100100;
  localparam logic [5:0] OR    = 6'b100101;
  localparam logic [5:0] SLT   = 6'b101010;
  localparam logic [5:0] SRL   = 6'b000010;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] NOP   = 6'b000000;
  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_SHT  = 2'b01;
  localparam logic [1:0] SEL_HILO = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  typedef struct packed {
    logic [5:0] sig;
    logic [1:0] sel;
    logic       ill;
  } dec_t;
  function automatic dec_t decode(input logic [5:0] f);
    case (f)
      ADD, SUB, AND, OR, SLT: decode = '{f, SEL_ALU, 1'b0};
      SRL:                    decode = '{SRL, SEL_SHT, 1'b0};
      MFHI, MFLO:             decode = '{f, SEL_HILO, 1'b0};
      MULTU:                  decode = '{MULTU, SEL_NONE, 1'b0};
      NOP:                    decode = '{NOP, SEL_NONE, 1'b0};
      default:                decode = '{NOP, SEL_NONE, 1'b1};
    endcase
  endfunction
endpackage

// File: rtl/alu_control_if.sv
// alu_control_if: funct handshake in, decoded control bus out
interface alu_control_if;
  logic [5:0] funct;
  logic       funct_valid;
  logic       funct_ready;
  logic [5:0] Signal;
  logic [1:0] out_sel;
  logic       hilo_sel;
  logic       mul_start;
  logic       mul_busy;
  logic       mul_done;
  logic       illegal;
  modport master (output funct, funct_valid,
                  input  funct_ready, Signal, out_sel, hilo_sel, mul_start, mul_busy, mul_done, illegal);
  modport slave  (input  funct, funct_valid,
                  output funct_ready, Signal, out_sel, hilo_sel, mul_start, mul_busy, mul_done, illegal);
endinterface

// File: rtl/alu_control_mul_cycle_counter.sv
// mul_cycle_counter: loadable down-counter that stops at zero
module mul_cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/alu_control.sv
// alu_control: registered funct decode with MULTU sequencing that stalls the handshake
module alu_control
  import alu_control_pkg::*;
#(
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input logic         clk,
  input logic         reset,
  alu_control_if.slave bus
);
  logic [1:0] r_state;
  logic [5:0] r_signal;
  logic [1:0] r_out_sel;
  logic       r_hilo_sel;
  logic       r_mul_start;
  logic       r_illegal;
  logic       w_accept;
  logic       w_mul;
  logic       w_zero;
  dec_t       w_dec;
  assign w_accept = bus.funct_valid && bus.funct_ready;
  assign w_dec    = decode(bus.funct);
  assign w_mul    = w_accept && bus.funct == MULTU;
  mul_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_mul),
    .i_load_val (CNT_W'(MUL_CYCLES - 1)),
    .i_dec      (r_state == S_RUN),
    .o_zero     (w_zero)
  );
  // MUL_DONE falls through to IDLE unless a new MULTU is taken in the same cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state     <= S_IDLE;
      r_signal    <= NOP;
      r_out_sel   <= SEL_NONE;
      r_hilo_sel  <= 1'b0;
      r_mul_start <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_mul_start <= w_mul;
      r_illegal   <= w_accept && w_dec.ill;
      if (w_accept) begin
        r_signal   <= w_dec.sig;
        r_out_sel  <= w_dec.sel;
        r_hilo_sel <= bus.funct == MFHI;
      end
      r_state <= w_mul ? S_RUN : r_state == S_RUN ? (w_zero ? S_DONE : S_RUN) : S_IDLE;
    end
  assign bus.funct_ready = r_state != S_RUN;
  assign bus.mul_busy    = r_state == S_RUN;
  assign bus.mul_done    = r_state == S_DONE;
  assign bus.Signal      = r_signal;
  assign bus.out_sel     = r_out_sel;
  assign bus.hilo_sel    = r_hilo_sel;
  assign bus.mul_start   = r_mul_start;
  assign bus.illegal     = r_illegal;
endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: table-driven decode checks plus MULTU stall and reset-abort sequences
module tb_alu_control;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_pass = 0;
  int   n_tot = 0;
  alu_control_if bus();
  alu_control #(.MUL_CYCLES(32), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [5:0] f;
    logic [5:0] sig;
    logic [1:0] sel;
    logic       hs;
    logic       ill;
  } vec_t;
  vec_t v[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [5:0] f, input logic vld);
    bus.funct = f;
    bus.funct_valid = vld;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic seen;
    v[0]  = '{6'b100000, 6'b100000, 2'b00, 1'b0, 1'b0};
    v[1]  = '{6'b000010, 6'b000010, 2'b01, 1'b0, 1'b0};
    v[2]  = '{6'b100010, 6'b100010, 2'b00, 1'b0, 1'b0};
    v[3]  = '{6'b100100, 6'b100100, 2'b00, 1'b0, 1'b0};
    v[4]  = '{6'b100101, 6'b100101, 2'b00, 1'b0, 1'b0};
    v[5]  = '{6'b101010, 6'b101010, 2'b00, 1'b0, 1'b0};
    v[6]  = '{6'b010000, 6'b010000, 2'b10, 1'b1, 1'b0};
    v[7]  = '{6'b010010, 6'b010010, 2'b10, 1'b0, 1'b0};
    v[8]  = '{6'b111111, 6'b000000, 2'b11, 1'b0, 1'b1};
    v[9]  = '{6'b100000, 6'b100000, 2'b00, 1'b0, 1'b0};
    v[10] = '{6'b000000, 6'b000000, 2'b11, 1'b0, 1'b0};
    v[11] = '{6'b000010, 6'b000010, 2'b01, 1'b0, 1'b0};
    drive(6'b000010, 1'b1);
    repeat (2) @(posedge clk);
    #3;
    chk("rst_signal", bus.Signal, 6'b000000);
    chk("rst_out_sel", bus.out_sel, 2'b11);
    chk("rst_ready", bus.funct_ready, 1'b1);
    chk("rst_busy", bus.mul_busy, 1'b0);
    chk("rst_pulses", {bus.mul_start, bus.mul_done, bus.illegal, bus.hilo_sel}, 4'b0000);
    reset = 1'b1;
    step();
    chk("first_signal", bus.Signal, 6'b000010);
    chk("first_out_sel", bus.out_sel, 2'b01);
    for (int i = 0; i < 12; i++) begin
      drive(v[i].f, 1'b1);
      step();
      chk($sformatf("vec%0d_signal", i), bus.Signal, v[i].sig);
      chk($sformatf("vec%0d_out_sel", i), bus.out_sel, v[i].sel);
      chk($sformatf("vec%0d_illegal", i), bus.illegal, v[i].ill);
      if (v[i].sel == 2'b10) chk($sformatf("vec%0d_hilo", i), bus.hilo_sel, v[i].hs);
    end
    drive(6'b011001, 1'b1);
    step();
    chk("mul_c1_start", bus.mul_start, 1'b1);
    chk("mul_c1_busy", bus.mul_busy, 1'b1);
    chk("mul_c1_ready", bus.funct_ready, 1'b0);
    chk("mul_c1_signal", bus.Signal, 6'b011001);
    chk("mul_c1_out_sel", bus.out_sel, 2'b11);
    drive(6'b000010, 1'b1);
    for (int c = 2; c <= 32; c++) begin
      step();
      chk($sformatf("mul_c%0d_state", c), {bus.mul_start, bus.mul_busy, bus.funct_ready, bus.mul_done}, 4'b0100);
    end
    step();
    chk("mul_c33_done", bus.mul_done, 1'b1);
    chk("mul_c33_busy", bus.mul_busy, 1'b0);
    chk("mul_c33_ready", bus.funct_ready, 1'b1);
    chk("mul_c33_signal", bus.Signal, 6'b011001);
    step();
    chk("mul_c34_signal", bus.Signal, 6'b000010);
    chk("mul_c34_out_sel", bus.out_sel, 2'b01);
    chk("mul_c34_done", bus.mul_done, 1'b0);
    drive(6'b011001, 1'b1);
    step();
    drive(6'b000000, 1'b0);
    repeat (32) step();
    chk("b2b_done", bus.mul_done, 1'b1);
    drive(6'b011001, 1'b1);
    step();
    chk("b2b_restart", {bus.mul_start, bus.mul_busy, bus.mul_done}, 3'b110);
    drive(6'b000000, 1'b0);
    repeat (9) step();
    chk("abort_busy_pre", bus.mul_busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", bus.mul_busy, 1'b0);
    chk("abort_signal", bus.Signal, 6'b000000);
    chk("abort_out_sel", bus.out_sel, 2'b11);
    chk("abort_ready", bus.funct_ready, 1'b1);
    repeat (2) step();
    reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      seen = seen | bus.mul_done | bus.mul_busy;
    end
    chk("abort_no_done", seen, 1'b0);
    chk("abort_ready_after", bus.funct_ready, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/alu_control.md
Name: alu_control

Overview:
- Sequential decode/sequencing stage directly upstream of the ALU, the SRL shifter, the multiplier and the HiLo/result mux.
- Accepts a 6-bit R-type funct code through a valid/ready handshake and drives the registered 6-bit Signal bus that those units compare against.
- Sequences the fixed-length MULTU operation with a cycle counter, stalling further instructions until the multiply completes.

Parameters:
MUL_CYCLES, 32, number of cycles the multiplier runs per MULTU (minimum 1)
CNT_W, 6, counter width; must hold MUL_CYCLES-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
funct  input  6  funct code of the current instruction
funct_valid  input  1  funct is valid this cycle
funct_ready  output  1  block can accept funct this cycle
Signal  output  6  registered operation code to ALU/Shifter/multiplier
out_sel  output  2  result mux select: 00 ALU, 01 shifter, 10 HiLo, 11 no write
hilo_sel  output  1  HiLo read select: 1 HI, 0 LO
mul_start  output  1  one-cycle pulse that starts the multiplier
mul_busy  output  1  multiplier running
mul_done  output  1  one-cycle pulse when the multiply ends
illegal  output  1  one-cycle pulse when an unknown funct is accepted

Behaviour:
- Legal codes: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, SRL 000010, MULTU 011001, MFHI 010000, MFLO 010010. 000000 is NOP.
- Reset values (async, while reset=0): Signal=000000, out_sel=11, hilo_sel=0, mul_start=0, mul_busy=0, mul_done=0, illegal=0, state=IDLE, counter=0, funct_ready=1 after release.
- Accept: funct_valid && funct_ready at a rising edge. Latency is 1 cycle: the outputs are updated at that edge.
- Requests without ready are ignored. Nothing is queued; upstream must hold funct and funct_valid.
- Decode of an accepted code:
  - ADD/SUB/AND/OR/SLT: Signal=funct, out_sel=00.
  - SRL: Signal=000010, out_sel=01.
  - MFHI/MFLO: Signal=funct, out_sel=10, hilo_sel=1 for MFHI and 0 for MFLO.
  - MULTU: Signal=011001, out_sel=11, mul_start=1 for one cycle.
  - Any other code: Signal=000000, out_sel=11, illegal=1 for one cycle.
- Signal, out_sel and hilo_sel hold until the next accept. The shifter holds its output whenever Signal != SRL, so a NOP leaves the shifter result untouched.
- FSM states are IDLE, MUL_RUN and MUL_DONE.
  - IDLE: funct_ready=1. Accepting MULTU moves to MUL_RUN and loads the counter with MUL_CYCLES-1.
  - MUL_RUN: funct_ready=0, mul_busy=1, counter decrements each cycle. When counter==0, move to MUL_DONE. mul_busy is high for exactly MUL_CYCLES cycles.
  - MUL_DONE: mul_done=1 for one cycle, funct_ready=1. An accept here is handled exactly as from IDLE, including a back-to-back MULTU. With no accept, go to IDLE.
- Timing: MULTU accepted at edge 0 gives mul_start in cycle 1, mul_busy in cycles 1..MUL_CYCLES, and mul_done in cycle MUL_CYCLES+1.
- mul_start and mul_busy overlap in the first run cycle.
- Reset mid-multiply aborts immediately: outputs go to reset values and no mul_done is issued.
- funct_valid held high across the MULTU stall: the instruction is accepted at the first edge in MUL_DONE.
- Pulse outputs (mul_start, mul_done, illegal) never last more than one cycle, except when back-to-back accepts legitimately repeat them.

Decomposition:
- Shared package holds:
  - funct code localparams (ADD, SUB, AND, OR, SLT, SRL, MULTU, MFHI, MFLO, NOP), reused by the ALU and the Shifter;
  - out_sel encodings (SEL_ALU, SEL_SHT, SEL_HILO, SEL_NONE);
  - FSM state encodings.
- One sub-module: mul_cycle_counter (load, decrement, zero flag), parameterised by CNT_W.

Test Plan:
- Hold reset low with funct=000010 and valid=1, then release → Signal=000000, out_sel=11, funct_ready=1 while in reset; after the first edge, Signal=000010 and out_sel=01.
- funct=100000 accepted, then 000010 on the next cycle → Signal 100000/out_sel 00, then 000010/01 one cycle after each accept.
- funct=011001 accepted at edge 0, with 000010 held valid afterwards:
  - mul_start=1 in cycle 1 only;
  - funct_ready=0 and mul_busy=1 for cycles 1..32;
  - mul_done=1 in cycle 33, when SRL is accepted; Signal=000010 in cycle 34.
- funct=111111 accepted → illegal=1 for one cycle, Signal=000000, out_sel=11; the next legal funct clears illegal.
- MULTU accepted, reset pulled low in cycle 10 → mul_busy=0 and Signal=000000 without waiting for an edge; no mul_done ever; funct_ready=1 after release.
- MFHI then MFLO back-to-back → out_sel=10 both cycles, hilo_sel=1 then 0, Signal 010000 then 010010.
